seq_lock_monitor: RTL and testbench

SEQ_LOCK_MONITOR -- requirements
Module: seq_lock_monitor

---
 rtl/seq_mon_pkg.sv | 46 ++++
 rtl/seq_lock_monitor_if.sv | 44 ++++
 rtl/seq_code_decode.sv | 32 +++
 rtl/seq_lock_monitor.sv | 157 +++++++++++++++
 tb/tb_seq_lock_monitor.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// seq_mon_pkg
// Shared definitions for the sequence lock monitor:
//   - state_e      : monitor FSM states (search / acquire / locked)
//   - CODE_0..7    : the eight legal codes, in sequence order
//   - code_at()    : code stored at a sequence position
//   - next_index() : sequence position that follows a given one (wraps 7 -> 0)
// -----------------------------------------------------------------------------
package seq_mon_pkg;

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2
    } state_e;

    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b1101;
    localparam logic [3:0] CODE_2 = 4'b1011;
    localparam logic [3:0] CODE_3 = 4'b1001;
    localparam logic [3:0] CODE_4 = 4'b0110;
    localparam logic [3:0] CODE_5 = 4'b1100;
    localparam logic [3:0] CODE_6 = 4'b0011;
    localparam logic [3:0] CODE_7 = 4'b1111;

    function automatic logic [3:0] code_at(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            3'd0:    code = CODE_0;
            3'd1:    code = CODE_1;
            3'd2:    code = CODE_2;
            3'd3:    code = CODE_3;
            3'd4:    code = CODE_4;
            3'd5:    code = CODE_5;
            3'd6:    code = CODE_6;
            default: code = CODE_7;
        endcase
        return code;
    endfunction

    // 3-bit arithmetic gives the 7 -> 0 wrap for free.
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/seq_lock_monitor_if.sv
// -----------------------------------------------------------------------------
// seq_lock_monitor_if
// Sample stream and status bundle of the sequence lock monitor.
//   sample_en, q_in            : sample strobe and 4-bit code (master -> slave)
//   locked, err, index,
//   expected, lap_cnt, err_cnt : monitor status (slave -> master)
// Modports: master = stimulus / consumer side, slave = the monitor.
// -----------------------------------------------------------------------------
interface seq_lock_monitor_if #(
    parameter int unsigned LAP_W = 8
) ();

    logic             sample_en;
    logic [3:0]       q_in;
    logic             locked;
    logic             err;
    logic [2:0]       index;
    logic [3:0]       expected;
    logic [LAP_W-1:0] lap_cnt;
    logic [LAP_W-1:0] err_cnt;

    modport master (
        output sample_en,
        output q_in,
        input  locked,
        input  err,
        input  index,
        input  expected,
        input  lap_cnt,
        input  err_cnt
    );

    modport slave (
        input  sample_en,
        input  q_in,
        output locked,
        output err,
        output index,
        output expected,
        output lap_cnt,
        output err_cnt
    );

endinterface

// File: rtl/seq_code_decode.sv
// -----------------------------------------------------------------------------
// seq_code_decode
// Combinational lookup of a 4-bit code in the legal sequence.
//   i_code  : code to look up
//   o_legal : 1 when i_code is one of the eight sequence codes
//   o_index : position of i_code in the sequence (0 when illegal)
// -----------------------------------------------------------------------------
module seq_code_decode
    import seq_mon_pkg::*;
(
    input  logic [3:0] i_code,
    output logic       o_legal,
    output logic [2:0] o_index
);

    always_comb begin
        o_legal = 1'b1;
        o_index = 3'd0;
        case (i_code)
            CODE_0:  o_index = 3'd0;
            CODE_1:  o_index = 3'd1;
            CODE_2:  o_index = 3'd2;
            CODE_3:  o_index = 3'd3;
            CODE_4:  o_index = 3'd4;
            CODE_5:  o_index = 3'd5;
            CODE_6:  o_index = 3'd6;
            CODE_7:  o_index = 3'd7;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_lock_monitor.sv
// -----------------------------------------------------------------------------
// seq_lock_monitor
// Tracks a repeating 8-code sequence from an upstream counter, declares lock
// after LOCK_COUNT consecutive correct transitions, flywheels through up to
// MISS_LIMIT-1 consecutive mismatches while locked, and counts laps / errors.
//
// Ports:
//   clk   : clock, all state updates on its rising edge
//   clear : synchronous active-high reset, overrides sample_en
//   bus   : seq_lock_monitor_if.slave (sample_en, q_in in; status out)
//
// Parameters: LOCK_COUNT (1..15), MISS_LIMIT (1..15), LAP_W (counter width).
//
// Build option: define SEQ_MON_ERRCNT_EN to get the saturating err_cnt
// counter; without it err_cnt is tied to zero and no register exists.
// All outputs are registered (one cycle latency from the sampling edge).
// -----------------------------------------------------------------------------
module seq_lock_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 2,
    parameter int unsigned LAP_W      = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    seq_lock_monitor_if.slave    bus
);

    localparam logic [3:0] LockCountC = 4'(LOCK_COUNT);
    localparam logic [3:0] MissLimitC = 4'(MISS_LIMIT);

    state_e           r_state, w_state_next;
    logic [2:0]       r_index, w_index_next;
    logic [3:0]       r_expected;
    logic [3:0]       r_good, w_good_next, w_good_inc;
    logic [3:0]       r_miss, w_miss_next, w_miss_inc;
    logic             r_err, w_err_next;
    logic             r_locked;
    logic [LAP_W-1:0] r_lap, w_lap_next;
    logic             w_err_inc;
    logic             w_legal;
    logic [2:0]       w_dec_index;
    logic             w_match;

    seq_code_decode u_decode (
        .i_code  (bus.q_in),
        .o_legal (w_legal),
        .o_index (w_dec_index)
    );

    // r_expected always holds the code after r_index, so a match is one compare.
    assign w_match    = (bus.q_in == r_expected);
    assign w_good_inc = r_good + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_good_next  = r_good;
        w_miss_next  = r_miss;
        w_lap_next   = r_lap;
        w_err_next   = 1'b0;
        w_err_inc    = 1'b0;

        if (bus.sample_en) begin
            unique case (r_state)
                StSearch: begin
                    if (w_legal) begin
                        w_index_next = w_dec_index;
                        w_good_next  = 4'd0;
                        w_state_next = StAcquire;
                    end
                end
                StAcquire: begin
                    if (w_match) begin
                        w_index_next = next_index(r_index);
                        w_good_next  = w_good_inc;
                        if (w_good_inc == LockCountC) begin
                            w_state_next = StLocked;
                            w_miss_next  = 4'd0;
                        end
                    end else if (w_legal) begin
                        w_index_next = w_dec_index;
                        w_good_next  = 4'd0;
                    end else begin
                        w_state_next = StSearch;
                    end
                end
                StLocked: begin
                    // Index advances on hits and misses alike (flywheel).
                    w_index_next = next_index(r_index);
                    if (w_match) begin
                        w_miss_next = 4'd0;
                        if (r_index == 3'd7) begin
                            w_lap_next = r_lap + LAP_W'(1);
                        end
                    end else begin
                        w_err_next  = 1'b1;
                        w_err_inc   = 1'b1;
                        w_miss_next = w_miss_inc;
                        if (w_miss_inc == MissLimitC) begin
                            w_state_next = StSearch;
                            w_miss_next  = 4'd0;
                        end
                    end
                end
                default: w_state_next = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= StSearch;
            r_index    <= 3'd0;
            r_expected <= CODE_1;
            r_good     <= 4'd0;
            r_miss     <= 4'd0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
            r_lap      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_index    <= w_index_next;
            r_expected <= code_at(next_index(w_index_next));
            r_good     <= w_good_next;
            r_miss     <= w_miss_next;
            r_err      <= w_err_next;
            r_locked   <= (w_state_next == StLocked);
            r_lap      <= w_lap_next;
        end
    end

`ifdef SEQ_MON_ERRCNT_EN
    logic [LAP_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + LAP_W'(1);
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.locked   = r_locked;
    assign bus.err      = r_err;
    assign bus.index    = r_index;
    assign bus.expected = r_expected;
    assign bus.lap_cnt  = r_lap;

endmodule

// File: tb/tb_seq_lock_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_lock_monitor
// Self-checking bench for seq_lock_monitor. A reference model built from the
// sequence rules (code table lookup, integer counters) is stepped on every
// clock edge alongside the DUT. err_cnt expectations follow SEQ_MON_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_seq_lock_monitor;

    localparam int unsigned LOCK_COUNT = 3;
    localparam int unsigned MISS_LIMIT = 2;
    localparam int unsigned LAP_W      = 8;
    localparam int          M_SEARCH   = 0;
    localparam int          M_ACQUIRE  = 1;
    localparam int          M_LOCKED   = 2;
    localparam int          CNT_MAX    = (1 << LAP_W) - 1;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    always #5 clk = ~clk;

    seq_lock_monitor_if #(.LAP_W(LAP_W)) bus ();

    seq_lock_monitor #(
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_LIMIT (MISS_LIMIT),
        .LAP_W      (LAP_W)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int seq_codes [8] = '{0, 13, 11, 9, 6, 12, 3, 15};

    // Reference model state
    int m_mode, m_idx, m_good, m_miss, m_lap, m_errcnt;
    bit m_err;

    function automatic int pos_of(input int q);
        for (int i = 0; i < 8; i++) if (seq_codes[i] == q) return i;
        return -1;
    endfunction

    function automatic int exp_errcnt();
`ifdef SEQ_MON_ERRCNT_EN
        return m_errcnt;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_code();
        return seq_codes[(m_idx + 1) % 8];
    endfunction

    function automatic void model_update(input bit en, input int q, input bit clr);
        int p;
        bit hit;
        p     = pos_of(q);
        hit   = (q == seq_codes[(m_idx + 1) % 8]);
        m_err = 1'b0;
        if (clr) begin
            m_mode = M_SEARCH; m_idx = 0; m_good = 0; m_miss = 0;
            m_lap = 0; m_errcnt = 0;
        end else if (en) begin
            if (m_mode == M_SEARCH) begin
                if (p >= 0) begin
                    m_idx = p; m_good = 0; m_mode = M_ACQUIRE;
                end
            end else if (m_mode == M_ACQUIRE) begin
                if (hit) begin
                    m_idx = (m_idx + 1) % 8;
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_mode = M_LOCKED; m_miss = 0;
                    end
                end else if (p >= 0) begin
                    m_idx = p; m_good = 0;
                end else begin
                    m_mode = M_SEARCH;
                end
            end else begin
                if (hit) begin
                    if (m_idx == 7) m_lap = (m_lap + 1) % (1 << LAP_W);
                    m_miss = 0;
                end else begin
                    m_err = 1'b1;
                    if (m_errcnt < CNT_MAX) m_errcnt++;
                    m_miss++;
                    if (m_miss == MISS_LIMIT) begin
                        m_mode = M_SEARCH; m_miss = 0;
                    end
                end
                m_idx = (m_idx + 1) % 8;
            end
        end
    endfunction

    // Apply one cycle of inputs, step the model at the edge, settle 1 time unit.
    task automatic step(input bit en, input logic [3:0] q, input bit clr);
        clear         = clr;
        bus.sample_en = en;
        bus.q_in      = q;
        @(posedge clk);
        model_update(en, int'(q), clr);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1101, 1'b1);
        checks++; if (bus.locked !== 1'b0) begin failures++;
            $display("FAIL reset_locked got %0b want 0", bus.locked); end
        checks++; if (bus.err !== 1'b0) begin failures++;
            $display("FAIL reset_err got %0b want 0", bus.err); end
        checks++; if (bus.index !== 3'd0) begin failures++;
            $display("FAIL reset_index got %0d want 0", bus.index); end
        checks++; if (bus.expected !== 4'b1101) begin failures++;
            $display("FAIL reset_expected got %b want 1101", bus.expected); end
        checks++; if (bus.lap_cnt !== '0) begin failures++;
            $display("FAIL reset_lap got %0d want 0", bus.lap_cnt); end
        checks++; if (bus.err_cnt !== '0) begin failures++;
            $display("FAIL reset_errcnt got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_acquire();
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1101, 1'b0);
        step(1'b1, 4'b1011, 1'b0);
        checks++; if (bus.locked !== 1'b0) begin failures++;
            $display("FAIL acq_early_lock got %0b want 0", bus.locked); end
        step(1'b1, 4'b1001, 1'b0);
        checks++; if (bus.locked !== 1'b1) begin failures++;
            $display("FAIL acq_locked got %0b want 1", bus.locked); end
        checks++; if (bus.index !== 3'd3) begin failures++;
            $display("FAIL acq_index got %0d want 3", bus.index); end
        checks++; if (bus.expected !== 4'b0110) begin failures++;
            $display("FAIL acq_expected got %b want 0110", bus.expected); end
    endtask

    task automatic test_laps();
        int errs_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(exp_code()), 1'b0);
            if (bus.err !== 1'b0) errs_seen++;
        end
        checks++; if (errs_seen != 0) begin failures++;
            $display("FAIL laps_err got %0d pulses want 0", errs_seen); end
        checks++; if (bus.lap_cnt !== LAP_W'(2)) begin failures++;
            $display("FAIL laps_count got %0d want 2", bus.lap_cnt); end
        checks++; if (bus.err_cnt !== '0) begin failures++;
            $display("FAIL laps_errcnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.locked !== 1'b1 || bus.index !== 3'd3) begin failures++;
            $display("FAIL laps_state got locked=%0b idx=%0d want 1/3", bus.locked, bus.index); end
    endtask

    // Sample slot for code index 2 receives 0101, then the true next code 1001.
    task automatic test_single_miss();
        int want_ec;
`ifdef SEQ_MON_ERRCNT_EN
        want_ec = 1;
`else
        want_ec = 0;
`endif
        // 4,5,6,7,0,1 -> last accepted index 1, one more lap
        for (int i = 0; i < 6; i++) step(1'b1, 4'(exp_code()), 1'b0);
        checks++; if (bus.expected !== 4'b1011) begin failures++;
            $display("FAIL miss_setup_expected got %b want 1011", bus.expected); end
        step(1'b1, 4'b0101, 1'b0);
        checks++; if (bus.err !== 1'b1) begin failures++;
            $display("FAIL miss_err_pulse got %0b want 1", bus.err); end
        checks++; if (bus.locked !== 1'b1 || bus.index !== 3'd2) begin failures++;
            $display("FAIL miss_flywheel got locked=%0b idx=%0d want 1/2", bus.locked, bus.index); end
        step(1'b1, 4'b1001, 1'b0);
        checks++; if (bus.err !== 1'b0) begin failures++;
            $display("FAIL miss_err_width got %0b want 0", bus.err); end
        checks++; if (bus.err_cnt !== LAP_W'(want_ec)) begin failures++;
            $display("FAIL miss_errcnt got %0d want %0d", bus.err_cnt, want_ec); end
        checks++; if (bus.locked !== 1'b1 || bus.lap_cnt !== LAP_W'(3)) begin failures++;
            $display("FAIL miss_hold_lock got locked=%0b lap=%0d want 1/3", bus.locked, bus.lap_cnt); end
    endtask

    task automatic test_loss();
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (bus.err !== 1'b1 || bus.locked !== 1'b1) begin failures++;
            $display("FAIL loss_first got err=%0b locked=%0b want 1/1", bus.err, bus.locked); end
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (bus.err !== 1'b1 || bus.locked !== 1'b0) begin failures++;
            $display("FAIL loss_second got err=%0b locked=%0b want 1/0", bus.err, bus.locked); end
        checks++; if (bus.lap_cnt !== LAP_W'(3) || bus.err_cnt !== LAP_W'(exp_errcnt())) begin
            failures++;
            $display("FAIL loss_counters got lap=%0d ec=%0d want 3/%0d",
                     bus.lap_cnt, bus.err_cnt, exp_errcnt()); end
        // Now in search: illegal code holds, no err outside lock.
        step(1'b1, 4'b0001, 1'b0);
        checks++; if (bus.err !== 1'b0 || bus.index !== 3'd5) begin failures++;
            $display("FAIL loss_search got err=%0b idx=%0d want 0/5", bus.err, bus.index); end
        step(1'b1, 4'b1100, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        checks++; if (bus.locked !== 1'b0) begin failures++;
            $display("FAIL relock_early got %0b want 0", bus.locked); end
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (bus.locked !== 1'b1 || bus.lap_cnt !== LAP_W'(3)) begin failures++;
            $display("FAIL relock got locked=%0b lap=%0d want 1/3", bus.locked, bus.lap_cnt); end
    endtask

    task automatic test_hold_and_clear();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            checks++;
            if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.index !== 3'd0 ||
                bus.expected !== 4'b1101 || bus.lap_cnt !== LAP_W'(3) ||
                bus.err_cnt !== LAP_W'(exp_errcnt())) begin
                failures++;
                $display("FAIL hold_%0d got l=%0b e=%0b i=%0d x=%b lap=%0d ec=%0d", i,
                         bus.locked, bus.err, bus.index, bus.expected, bus.lap_cnt, bus.err_cnt);
            end
        end
        step(1'b1, 4'b0110, 1'b1);
        checks++;
        if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.index !== 3'd0 ||
            bus.expected !== 4'b1101 || bus.lap_cnt !== '0 || bus.err_cnt !== '0) begin
            failures++;
            $display("FAIL clear_lock got l=%0b e=%0b i=%0d x=%b lap=%0d ec=%0d",
                     bus.locked, bus.err, bus.index, bus.expected, bus.lap_cnt, bus.err_cnt);
        end
        // First sample after release is searched: 1101 loads index 1, no lock yet.
        step(1'b1, 4'b1101, 1'b0);
        checks++; if (bus.locked !== 1'b0 || bus.index !== 3'd1) begin failures++;
            $display("FAIL clear_search got locked=%0b idx=%0d want 0/1", bus.locked, bus.index); end
        step(1'b1, 4'b1011, 1'b0);
        step(1'b1, 4'b1001, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        checks++; if (bus.locked !== 1'b1 || bus.index !== 3'd4) begin failures++;
            $display("FAIL clear_relock got locked=%0b idx=%0d want 1/4", bus.locked, bus.index); end
    endtask

    task automatic test_random();
        bit         en, clr;
        logic [3:0] q;
        int         r;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            en  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 199) == 0);
            r   = $urandom_range(0, 99);
            if (r < 70)      q = 4'(exp_code());
            else if (r < 88) q = 4'(seq_codes[$urandom_range(0, 7)]);
            else             q = 4'($urandom_range(0, 15));
            step(en, q, clr);
            checks++;
            if (bus.locked !== (m_mode == M_LOCKED) || bus.err !== m_err ||
                bus.index !== 3'(m_idx) || bus.expected !== 4'(exp_code()) ||
                bus.lap_cnt !== LAP_W'(m_lap) || bus.err_cnt !== LAP_W'(exp_errcnt())) begin
                failures++;
                $display("FAIL rand_c%0d got l=%0b e=%0b i=%0d x=%0d lap=%0d ec=%0d want %0b %0b %0d %0d %0d %0d",
                         cyc, bus.locked, bus.err, bus.index, bus.expected, bus.lap_cnt,
                         bus.err_cnt, (m_mode == M_LOCKED), m_err, m_idx, exp_code(), m_lap,
                         exp_errcnt());
            end
        end
    endtask

    // Alternate miss/hit while locked to saturate err_cnt, then run laps to wrap lap_cnt.
    task automatic test_saturation();
        int bad_err = 0;
        int want_ec;
`ifdef SEQ_MON_ERRCNT_EN
        want_ec = CNT_MAX;
`else
        want_ec = 0;
`endif
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1101, 1'b0);
        step(1'b1, 4'b1011, 1'b0);
        step(1'b1, 4'b1001, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'(seq_codes[(m_idx + 2) % 8]), 1'b0);
            if (bus.err !== 1'b1 || bus.locked !== 1'b1) bad_err++;
            step(1'b1, 4'(exp_code()), 1'b0);
        end
        checks++; if (bad_err != 0) begin failures++;
            $display("FAIL sat_pulses got %0d bad cycles want 0", bad_err); end
        checks++; if (bus.err_cnt !== LAP_W'(want_ec)) begin failures++;
            $display("FAIL sat_errcnt got %0d want %0d", bus.err_cnt, want_ec); end
        for (int i = 0; i < 2100; i++) step(1'b1, 4'(exp_code()), 1'b0);
        checks++; if (bus.lap_cnt !== LAP_W'(m_lap) || bus.locked !== 1'b1) begin failures++;
            $display("FAIL lap_wrap got lap=%0d locked=%0b want %0d/1",
                     bus.lap_cnt, bus.locked, m_lap); end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.q_in      = 4'd0;
        m_mode = M_SEARCH; m_idx = 0; m_good = 0; m_miss = 0;
        m_lap = 0; m_errcnt = 0; m_err = 1'b0;
        test_reset();
        test_acquire();
        test_laps();
        test_single_miss();
        test_loss();
        test_hold_and_clear();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
